// File: rtl/alu_pkg.sv
// alu_pkg: op codes shared with the ALU decoder and muldiv sequencer state encoding
package alu_pkg;
  localparam logic [4:0] OP_MUL    = 5'b01010;
  localparam logic [4:0] OP_MULH   = 5'b01011;
  localparam logic [4:0] OP_MULHSU = 5'b01100;
  localparam logic [4:0] OP_MULHU  = 5'b01101;
  localparam logic [4:0] OP_DIV    = 5'b01110;
  localparam logic [4:0] OP_DIVU   = 5'b01111;
  localparam logic [4:0] OP_REM    = 5'b10000;
  localparam logic [4:0] OP_REMU   = 5'b10001;
  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one combinational shift-add (multiply) or restoring shift-subtract (divide) step
// Ports: part = {hi, lo} partial product / {remainder, dividend}; opnd = multiplicand / divisor;
//        div selects divide; part_nxt = next partial value (divide: quotient bit slot left 0); q = quotient bit
module muldiv_iter #(
  parameter int NB_DATA = 32
) (
  input  logic [2*NB_DATA-1:0] part,
  input  logic [NB_DATA-1:0]   opnd,
  input  logic                 div,
  output logic [2*NB_DATA-1:0] part_nxt,
  output logic                 q
);
  logic [NB_DATA:0] sum, shr, dif;
  always_comb begin
    sum = {1'b0, part[2*NB_DATA-1:NB_DATA]} + (part[0] ? {1'b0, opnd} : '0);
    shr = part[2*NB_DATA-1:NB_DATA-1];
    dif = shr - {1'b0, opnd};
    q = div & ~dif[NB_DATA];
    part_nxt = div ? {q ? dif[NB_DATA-1:0] : shr[NB_DATA-1:0], part[NB_DATA-2:0], 1'b0}
                   : {sum, part[NB_DATA-1:1]};
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M multiply/divide unit with valid/ready request and result handshakes
// Ports: i_valid/o_ready request, i_alu_op/i_data1/i_data2 operands, i_flush abort,
//        o_valid/i_ready result, o_result value, o_busy stall. Macro MULDIV_FAST_MUL_EN: single-cycle multiply.
module muldiv_sequencer
  import alu_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_CTRL = 5
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [NB_CTRL-1:0] i_alu_op,
  input  logic [NB_DATA-1:0] i_data1,
  input  logic [NB_DATA-1:0] i_data2,
  input  logic               i_flush,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_busy
);
  localparam int NB_CNT = $clog2(NB_DATA) + 1;
  state_t               state;
  logic [NB_CTRL-1:0]   op;
  logic [2*NB_DATA-1:0] part, part_nxt, part_step;
  logic [NB_DATA-1:0]   opnd, mag_a, mag_b, spec_res;
  logic [NB_CNT-1:0]    cnt;
  logic                 neg_q, neg_r, q_bit, a_neg, b_neg, is_mul_in, is_div_in, dz, ovf, special;
  // Result fix-up: p holds the unsigned product, or {remainder, quotient}; neg_q also carries the product sign
  function automatic logic [NB_DATA-1:0] fix(input logic [NB_CTRL-1:0] f, input logic [2*NB_DATA-1:0] p,
                                             input logic nq, input logic nr);
    logic [2*NB_DATA-1:0] sp;
    logic [NB_DATA-1:0]   r;
    sp = nq ? -p : p;
    r  = nr ? -p[2*NB_DATA-1:NB_DATA] : p[2*NB_DATA-1:NB_DATA];
    return (f == OP_MUL || f == OP_DIV || f == OP_DIVU) ? sp[NB_DATA-1:0]
         : (f inside {OP_MULH, OP_MULHSU, OP_MULHU}) ? sp[2*NB_DATA-1:NB_DATA] : r;
  endfunction
  always_comb begin
    is_mul_in = i_alu_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    is_div_in = i_alu_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    a_neg = (i_alu_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) & i_data1[NB_DATA-1];
    b_neg = (i_alu_op inside {OP_MULH, OP_DIV, OP_REM}) & i_data2[NB_DATA-1];
    mag_a = a_neg ? -i_data1 : i_data1;
    mag_b = b_neg ? -i_data2 : i_data2;
    dz  = is_div_in && i_data2 == '0;
    ovf = (i_alu_op == OP_DIV || i_alu_op == OP_REM) && i_data1 == {1'b1, {(NB_DATA-1){1'b0}}} && &i_data2;
    spec_res = dz ? ((i_alu_op == OP_DIV || i_alu_op == OP_DIVU) ? '1 : i_data1)
             : (ovf && i_alu_op == OP_DIV) ? i_data1 : '0;
    special = dz | ovf | ~(is_mul_in | is_div_in);
    part_step = part_nxt | {{(2*NB_DATA-1){1'b0}}, q_bit};
  end
  muldiv_iter #(.NB_DATA(NB_DATA)) u_iter (
    .part     (part),
    .opnd     (opnd),
    .div      (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}),
    .part_nxt (part_nxt),
    .q        (q_bit)
  );
  assign o_ready = state == ST_IDLE;
  assign o_busy  = state != ST_IDLE;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      op       <= '0;
      part     <= '0;
      opnd     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      cnt      <= '0;
      o_valid  <= 1'b0;
      o_result <= '0;
    end else if (i_flush) begin
      state   <= ST_IDLE;
      o_valid <= 1'b0;
    end else
      case (state)
        ST_IDLE: if (i_valid) begin
          op    <= i_alu_op;
          part  <= {{NB_DATA{1'b0}}, mag_a};
          opnd  <= mag_b;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          cnt   <= '0;
          if (special) begin
            state    <= ST_DONE;
            o_valid  <= 1'b1;
            o_result <= spec_res;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (is_mul_in) begin
            state    <= ST_DONE;
            o_valid  <= 1'b1;
            o_result <= fix(i_alu_op, {{NB_DATA{1'b0}}, mag_a} * {{NB_DATA{1'b0}}, mag_b}, a_neg ^ b_neg, a_neg);
          end
`endif
          else
            state <= ST_CALC;
        end
        ST_CALC: begin
          part <= part_step;
          cnt  <= cnt + 1'b1;
          if (cnt == NB_CNT'(NB_DATA - 1)) begin
            state    <= ST_DONE;
            o_valid  <= 1'b1;
            o_result <= fix(op, part_step, neg_q, neg_r);
          end
        end
        ST_DONE: if (i_ready) begin
          state   <= ST_IDLE;
          o_valid <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
endmodule
